// File: rtl/ps2_pkg.sv
// Shared encodings for the PS/2 set-2 key decoder: prefix FSM states,
// prefix bytes, modifier scan codes and small byte classifiers.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXT    = 2'd1,
    S_BRK    = 2'd2,
    S_EXTBRK = 2'd3
  } state_t;

  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_BRK) || (b == PS2_EXT);
  endfunction

  // Controller responses and error bytes that never start a key sequence
  function automatic logic is_noise(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
           (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 scan code to ASCII lookup; letters honour 'upper',
// extended codes and unmapped codes give 0x00.
module ps2_scan2ascii (
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       upper,
  output logic [7:0] ascii
);

  logic [7:0] lower;
  logic [7:0] other;

  always_comb begin
    lower = 8'h00;
    case (code)
      8'h1C: lower = 8'h61;  8'h32: lower = 8'h62;  8'h21: lower = 8'h63;
      8'h23: lower = 8'h64;  8'h24: lower = 8'h65;  8'h2B: lower = 8'h66;
      8'h34: lower = 8'h67;  8'h33: lower = 8'h68;  8'h43: lower = 8'h69;
      8'h3B: lower = 8'h6A;  8'h42: lower = 8'h6B;  8'h4B: lower = 8'h6C;
      8'h3A: lower = 8'h6D;  8'h31: lower = 8'h6E;  8'h44: lower = 8'h6F;
      8'h4D: lower = 8'h70;  8'h15: lower = 8'h71;  8'h2D: lower = 8'h72;
      8'h1B: lower = 8'h73;  8'h2C: lower = 8'h74;  8'h3C: lower = 8'h75;
      8'h2A: lower = 8'h76;  8'h1D: lower = 8'h77;  8'h22: lower = 8'h78;
      8'h35: lower = 8'h79;  8'h1A: lower = 8'h7A;
      default: lower = 8'h00;
    endcase
  end

  always_comb begin
    other = 8'h00;
    case (code)
      8'h45: other = 8'h30;  8'h16: other = 8'h31;  8'h1E: other = 8'h32;
      8'h26: other = 8'h33;  8'h25: other = 8'h34;  8'h2E: other = 8'h35;
      8'h36: other = 8'h36;  8'h3D: other = 8'h37;  8'h3E: other = 8'h38;
      8'h46: other = 8'h39;
      8'h29: other = 8'h20;  8'h5A: other = 8'h0D;  8'h66: other = 8'h08;
      default: other = 8'h00;
    endcase
  end

  always_comb begin
    ascii = 8'h00;
    if (ext)
      ascii = 8'h00;
    else if (lower != 8'h00)
      ascii = upper ? (lower - 8'h20) : lower;
    else
      ascii = other;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Pops set-2 bytes from the keyboard FIFO, folds E0/F0 prefixes into key
// events, tracks shift/caps, maps to ASCII and counts new presses.
module ps2_key_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             ps2_nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_make,
  output logic             key_repeat,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic             caps_on,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_err
);

  import ps2_pkg::*;

  logic [7:0] byte_q;
  logic       pop_q;
  logic       hold_q;
  logic       accept;
  state_t     state_q, state_d;
  logic       ev, ev_make, ev_ext;

  logic       shift_l, shift_r, caps_held;
  logic [8:0] held_q;
  logic       is_lsh, is_rsh, is_caps, is_mod;
  logic       held_match, already_held, upper;
  logic [7:0] ascii_w;

  // The guard (pop_q, hold_q) keeps the FIFO from being read while the
  // previous pop is still being strobed and decoded.
  assign accept         = ps2_ready & ~pop_q & ~hold_q;
  assign ps2_nextdata_n = ~pop_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pop_q   <= 1'b0;
      hold_q  <= 1'b0;
      byte_q  <= 8'h00;
      state_q <= S_IDLE;
    end else begin
      pop_q   <= accept;
      hold_q  <= pop_q;
      state_q <= state_d;
      if (accept)
        byte_q <= ps2_data;
    end
  end

  always_comb begin
    state_d = state_q;
    ev      = 1'b0;
    ev_make = 1'b0;
    ev_ext  = 1'b0;
    if (pop_q) begin
      case (state_q)
        S_IDLE: begin
          if (byte_q == PS2_BRK)
            state_d = S_BRK;
          else if (byte_q == PS2_EXT)
            state_d = S_EXT;
          else if (!is_noise(byte_q)) begin
            ev      = 1'b1;
            ev_make = 1'b1;
          end
        end
        S_EXT: begin
          if (byte_q == PS2_BRK)
            state_d = S_EXTBRK;
          else if (byte_q != PS2_EXT) begin
            ev      = 1'b1;
            ev_make = 1'b1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          ev      = !is_prefix(byte_q);
        end
        S_EXTBRK: begin
          state_d = S_IDLE;
          ev      = !is_prefix(byte_q);
          ev_ext  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign is_lsh  = ~ev_ext & (byte_q == SC_LSHIFT);
  assign is_rsh  = ~ev_ext & (byte_q == SC_RSHIFT);
  assign is_caps = ~ev_ext & (byte_q == SC_CAPS);
  assign is_mod  = is_lsh | is_rsh | is_caps;

  assign held_match   = key_down & (held_q == {ev_ext, byte_q});
  assign already_held = is_lsh  ? shift_l   :
                        is_rsh  ? shift_r   :
                        is_caps ? caps_held : held_match;
  // Case is judged on modifier state before this event lands
  assign upper        = (shift_l | shift_r) ^ caps_on;

  ps2_scan2ascii u_scan2ascii (
    .code  (byte_q),
    .ext   (ev_ext),
    .upper (upper),
    .ascii (ascii_w)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_valid  <= 1'b0;
      key_code   <= 8'h00;
      key_ext    <= 1'b0;
      key_make   <= 1'b0;
      key_repeat <= 1'b0;
      key_ascii  <= 8'h00;
      key_down   <= 1'b0;
      caps_on    <= 1'b0;
      press_cnt  <= '0;
      ovf_err    <= 1'b0;
      shift_l    <= 1'b0;
      shift_r    <= 1'b0;
      caps_held  <= 1'b0;
      held_q     <= 9'h000;
    end else begin
      key_valid <= ev;
      if (ps2_overflow)
        ovf_err <= 1'b1;
      if (ev) begin
        key_code   <= byte_q;
        key_ext    <= ev_ext;
        key_make   <= ev_make;
        key_repeat <= ev_make & already_held;
        key_ascii  <= ascii_w;
        if (is_mod) begin
          if (is_lsh)
            shift_l <= ev_make;
          if (is_rsh)
            shift_r <= ev_make;
          if (is_caps) begin
            caps_held <= ev_make;
            if (ev_make && !caps_held)
              caps_on <= ~caps_on;
          end
        end else if (ev_make) begin
          if (!already_held) begin
            press_cnt <= press_cnt + CNT_W'(1);
            held_q    <= {ev_ext, byte_q};
            key_down  <= 1'b1;
          end
        end else if (held_match) begin
          key_down <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and randomized byte streams checked against a behavioural
// key-event model kept in the bench.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       ps2_overflow = 1'b0;
  logic       ps2_nextdata_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_make;
  logic       key_repeat;
  logic [7:0] key_ascii;
  logic       key_down;
  logic       caps_on;
  logic [7:0] press_cnt;
  logic       ovf_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_pop = -1;

  ps2_key_decoder #(.CNT_W(8)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ps2_data       (ps2_data),
    .ps2_ready      (ps2_ready),
    .ps2_overflow   (ps2_overflow),
    .ps2_nextdata_n (ps2_nextdata_n),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_ext        (key_ext),
    .key_make       (key_make),
    .key_repeat     (key_repeat),
    .key_ascii      (key_ascii),
    .key_down       (key_down),
    .caps_on        (caps_on),
    .press_cnt      (press_cnt),
    .ovf_err        (ovf_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  logic [7:0] letter_sc [0:25] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc [0:9] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] key_pool [0:10] = '{8'h1C, 8'h32, 8'h15, 8'h23, 8'h45, 8'h16,
    8'h29, 8'h5A, 8'h66, 8'h75, 8'h6B};
  logic [7:0] mod_pool [0:2]   = '{8'h12, 8'h59, 8'h58};
  logic [7:0] noise_pool [0:4] = '{8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};

  // Reference model state: pending prefixes as flags, keyboard as sets of flags
  bit       m_brk, m_ext, m_sl, m_sr, m_caps, m_capsh, m_down, m_ovf;
  bit [8:0] m_held;
  bit [7:0] m_cnt, m_code, m_ascii;
  bit       m_ev, m_mext, m_make, m_rep;

  function automatic bit [7:0] model_ascii(bit [7:0] c, bit e, bit up);
    if (e) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == c) return (up ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (digit_sc[i] == c) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_reset();
    {m_brk, m_ext, m_sl, m_sr, m_caps, m_capsh, m_down, m_ovf} = '0;
    m_held = '0; m_cnt = '0; m_code = '0; m_ascii = '0;
    {m_ev, m_mext, m_make, m_rep} = '0;
  endtask

  task automatic model_event(bit [7:0] c, bit e, bit mk);
    bit was_held;
    bit lsh, rsh, cps;
    lsh = !e && c == 8'h12;
    rsh = !e && c == 8'h59;
    cps = !e && c == 8'h58;
    was_held = lsh ? m_sl : rsh ? m_sr : cps ? m_capsh
             : (m_down && m_held == {e, c});
    m_ev = 1; m_code = c; m_mext = e; m_make = mk;
    m_ascii = model_ascii(c, e, (m_sl | m_sr) ^ m_caps);
    m_rep = mk && was_held;
    if (lsh) m_sl = mk;
    else if (rsh) m_sr = mk;
    else if (cps) begin
      if (mk && !m_capsh) m_caps = !m_caps;
      m_capsh = mk;
    end else if (mk) begin
      if (!was_held) begin m_cnt++; m_held = {e, c}; m_down = 1; end
    end else if (was_held) m_down = 0;
  endtask

  task automatic model_byte(bit [7:0] b);
    bit e;
    m_ev = 0;
    if (m_brk) begin
      e = m_ext; m_brk = 0; m_ext = 0;
      if (b != 8'hF0 && b != 8'hE0) model_event(b, e, 0);
    end else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_ext) begin m_ext = 0; model_event(b, 1, 1); end
    else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF})) model_event(b, 0, 1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("key_valid", key_valid, m_ev);
    check("key_code", key_code, m_code);
    check("key_ext", key_ext, m_mext);
    check("key_make", key_make, m_make);
    check("key_repeat", key_repeat, m_rep);
    check("key_ascii", key_ascii, m_ascii);
    check("key_down", key_down, m_down);
    check("caps_on", caps_on, m_caps);
    check("press_cnt", press_cnt, m_cnt);
    check("ovf_err", ovf_err, m_ovf);
  endtask

  // Caller is at a negedge; returns at the negedge where key_valid is due
  task automatic send_byte(input logic [7:0] b, input bit keep);
    int n;
    ps2_data  = b;
    ps2_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (ps2_nextdata_n !== 1'b0 && n < 20);
    if (ps2_nextdata_n !== 1'b0) begin
      check("pop_timeout", 32'd0, 32'd1);
      ps2_ready = 1'b0;
      return;
    end
    if (keep && last_pop >= 0) check("pop_spacing_ge3", (cyc - last_pop) >= 3, 1);
    last_pop = cyc;
    if (!keep) ps2_ready = 1'b0;
    model_byte(b);
    @(negedge clk);
    check("strobe_one_cycle", ps2_nextdata_n, 1'b1);
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; ps2_ready = 1'b0; last_pop = -1;
    model_reset();
    @(negedge clk);
    check("rst_nextdata_n", ps2_nextdata_n, 1'b1);
    check_outputs();
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    do_reset();

    // 1: make / break of q
    send_byte(8'h15, 0);
    check("t1_ascii_q", key_ascii, 8'h71);
    check("t1_cnt", press_cnt, 8'd1);
    send_byte(8'hF0, 0);
    send_byte(8'h15, 0);
    check("t1_break_down", key_down, 1'b0);
    @(negedge clk);
    check("t1_valid_pulse", key_valid, 1'b0);

    // 2: typematic repeat
    do_reset();
    send_byte(8'h23, 0);
    check("t2_rep0", key_repeat, 1'b0);
    send_byte(8'h23, 0);
    check("t2_rep1", key_repeat, 1'b1);
    send_byte(8'h23, 0);
    check("t2_rep2", key_repeat, 1'b1);
    check("t2_ascii_d", key_ascii, 8'h64);
    send_byte(8'hF0, 0);
    send_byte(8'h23, 0);
    check("t2_cnt", press_cnt, 8'd1);

    // 3: shift then caps
    send_byte(8'h12, 0);
    send_byte(8'h1C, 0);
    check("t3_shift_A", key_ascii, 8'h41);
    send_byte(8'hF0, 0); send_byte(8'h12, 0);
    send_byte(8'h58, 0); send_byte(8'hF0, 0); send_byte(8'h58, 0);
    send_byte(8'h1C, 0);
    check("t3_caps_A", key_ascii, 8'h41);
    check("t3_caps_on", caps_on, 1'b1);
    check("t3_cnt", press_cnt, 8'd2);

    // 4: extended make/break, then malformed F0 E0
    send_byte(8'hE0, 0); send_byte(8'h75, 0);
    check("t4_ext", key_ext, 1'b1);
    check("t4_ascii0", key_ascii, 8'h00);
    send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
    check("t4_break", key_make, 1'b0);
    send_byte(8'hF0, 0); send_byte(8'hE0, 0);
    check("t4_dropped", key_valid, 1'b0);
    send_byte(8'hAA, 0);
    send_byte(8'h16, 0);

    // 5: ready held high, 256 new presses wrap the counter; overflow pulse
    do_reset();
    for (int i = 0; i < 256; i++) send_byte((i % 2) ? 8'h32 : 8'h1C, 1);
    ps2_ready = 1'b0;
    check("t5_wrap", press_cnt, 8'd0);
    ps2_overflow = 1'b1; @(negedge clk); ps2_overflow = 1'b0; m_ovf = 1;
    @(negedge clk);
    check("t5_ovf", ovf_err, 1'b1);
    last_pop = -1;

    // Randomized byte stream
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      case ($urandom_range(0, 9))
        0: b = 8'hF0;
        1: b = 8'hE0;
        2: b = mod_pool[$urandom_range(0, 2)];
        3: b = ($urandom_range(0, 1) != 0) ? noise_pool[$urandom_range(0, 4)] : 8'($urandom);
        default: b = key_pool[$urandom_range(0, 10)];
      endcase
      send_byte(b, 1'($urandom_range(0, 1)));
      if (ps2_ready && $urandom_range(0, 3) == 0) begin
        ps2_ready = 1'b0; last_pop = -1; @(negedge clk);
      end
    end
    ps2_ready = 1'b0; last_pop = -1;
    @(negedge clk);
    check("t5_ovf_sticky", ovf_err, 1'b1);

    // 6: reset while the pop strobe is low
    send_byte(8'h32, 0); send_byte(8'h1C, 0);
    ps2_data = 8'h23; ps2_ready = 1'b1;
    for (int n = 0; n < 20 && ps2_nextdata_n !== 1'b0; n++) @(negedge clk);
    check("t6_strobe_seen", ps2_nextdata_n, 1'b0);
    resetn = 1'b0;
    #1;
    check("t6_strobe_release", ps2_nextdata_n, 1'b1);
    model_reset();
    check_outputs();
    ps2_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outputs();
    end
    send_byte(8'h15, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
